// File: rtl/cim_pkg.sv
// cim_pkg: shared constants and types for compute-in-memory bank sequencers
//   CIM_ROWS  - rows per bank, equals the one-hot row-select width
//   CIM_DW    - row word width, equals the bank data bus width
//   CIM_CNT_W - settle counter width (settle time 1..15 cycles)
//   loader_state_t - bank loader FSM states
package cim_pkg;
    localparam int CIM_ROWS  = 8;
    localparam int CIM_DW    = 24;
    localparam int CIM_CNT_W = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WRITE, ST_DONE} loader_state_t;
endpackage

// File: rtl/cim_row_pick.sv
// cim_row_pick: lowest-set-bit priority encoder, mask -> one-hot row plus any flag
//   mask   in  ROWS  candidate rows
//   onehot out ROWS  lowest set bit of mask, 0 when mask is 0
//   any    out 1     mask has at least one bit set
module cim_row_pick
    import cim_pkg::*;
#(
    parameter int ROWS = CIM_ROWS
) (
    input  logic [ROWS-1:0] mask,
    output logic [ROWS-1:0] onehot,
    output logic            any
);
    // Two's-complement trick isolates the lowest set bit.
    assign onehot = mask & (~mask + ROWS'(1));
    assign any    = |mask;
endmodule

// File: rtl/cim_bank_loader.sv
// cim_bank_loader: streams row words into one CIM bank in ascending masked-row order
//   clk, rst            clock, synchronous active-high reset
//   start, row_mask     begin a load of the masked rows (sampled in IDLE only)
//   abort               end a load early (current row still completes its settle)
//   s_valid/s_ready/s_data  row word stream
//   D, WA               registered bank data bus and one-hot row select
//   busy, done, loaded  status: in progress, completion pulse, sticky per-row loaded flags
//   stall_cnt           FETCH cycles starved of s_valid, saturating; present only
//                       when CIM_LOADER_STALL_CNT_EN is defined
module cim_bank_loader
    import cim_pkg::*;
#(
    parameter int ROWS       = CIM_ROWS,
    parameter int DW         = CIM_DW,
    parameter int SETTLE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ROWS-1:0] row_mask,
    input  logic            abort,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    output logic [DW-1:0]   D,
    output logic [ROWS-1:0] WA,
    output logic            busy,
    output logic            done,
    output logic [ROWS-1:0] loaded
`ifdef CIM_LOADER_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);
    loader_state_t        state, state_nx;
    logic [ROWS-1:0]      mask, pick, mask_left;
    logic                 any;
    logic [CIM_CNT_W-1:0] cnt;
    logic                 abort_q;
    logic                 hs, last, stop;

    // In IDLE the encoder looks at the incoming mask so "any" decides an empty
    // load; afterwards it selects the next row to write from the latched mask.
    cim_row_pick #(.ROWS(ROWS)) u_pick (
        .mask   (state == ST_IDLE ? row_mask : mask),
        .onehot (pick),
        .any    (any)
    );

    assign hs        = s_valid && s_ready;
    assign last      = (state == ST_WRITE) && (cnt == CIM_CNT_W'(1));
    assign stop      = abort_q || abort;
    assign mask_left = mask & ~WA;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  state_nx = start ? (any ? ST_FETCH : ST_DONE) : ST_IDLE;
            ST_FETCH: state_nx = abort ? ST_IDLE : (s_valid ? ST_WRITE : ST_FETCH);
            ST_WRITE: state_nx = !last ? ST_WRITE : stop ? ST_IDLE : |mask_left ? ST_FETCH : ST_DONE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // s_ready drops under abort so a word offered in the aborting cycle is not consumed.
    always_comb begin
        s_ready = (state == ST_FETCH) && !abort;
        busy    = state != ST_IDLE;
        done    = state == ST_DONE;
    end

    // WA never returns to 0 between writes: the bank would decode that as row 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            D       <= '0;
            WA      <= ROWS'(1);
            mask    <= '0;
            loaded  <= '0;
            cnt     <= '0;
            abort_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                mask   <= row_mask;
                loaded <= loaded & ~row_mask;
            end
            if (hs) begin
                D   <= s_data;
                WA  <= pick;
                cnt <= CIM_CNT_W'(SETTLE_CYC);
            end
            if (state == ST_WRITE) begin
                cnt     <= cnt - CIM_CNT_W'(1);
                abort_q <= abort_q || abort;
            end else begin
                abort_q <= 1'b0;
            end
            if (last) begin
                loaded <= loaded | WA;
                mask   <= mask_left;
            end
        end
    end

`ifdef CIM_LOADER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && start))
            stall_cnt <= '0;
        else if (state == ST_FETCH && !s_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule
